// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bundle: branch redirect, hazard stall, instruction-memory
// handshake and the IF/ID register outputs.
interface if_fetch_ctrl_if;
    logic        do_branch;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        flush_id;

    modport master (
        input  do_branch, branch_target, stall, imem_ready, imem_rdata,
        output imem_req, imem_addr, ifid_valid, ifid_pc, ifid_inst, flush_id
    );

    modport slave (
        output do_branch, branch_target, stall, imem_ready, imem_rdata,
        input  imem_req, imem_addr, ifid_valid, ifid_pc, ifid_inst, flush_id
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the imem valid/ready
// request, loads IF/ID and redirects on EX-stage branch decisions.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic            clk,
    input logic            rst_n,
    if_fetch_ctrl_if.master bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] BUF  = 2'd2;
    localparam logic [1:0] KILL = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic [31:0] target;

    assign target = {bus.branch_target[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        buf_inst_d    = buf_inst_q;
        ifid_valid_d  = ifid_valid_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_inst_d   = ifid_inst_q;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.do_branch && bus.imem_ready) begin
                    pc_d = target;
                end else if (bus.do_branch) begin
                    // Address must stay stable until the pending request completes.
                    redirect_pc_d = target;
                    state_d       = KILL;
                end else if (bus.imem_ready && !bus.stall) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = pc_q;
                    ifid_inst_d  = bus.imem_rdata;
                    pc_d         = pc_q + 32'd4;
                end else if (bus.imem_ready) begin
                    buf_inst_d = bus.imem_rdata;
                    state_d    = BUF;
                end else if (!bus.stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = NOP_INST;
                end
            end
            BUF: begin
                if (bus.do_branch) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (!bus.stall) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = pc_q;
                    ifid_inst_d  = buf_inst_q;
                    pc_d         = pc_q + 32'd4;
                    state_d      = REQ;
                end
            end
            KILL: begin
                if (bus.imem_ready) begin
                    pc_d    = bus.do_branch ? target : redirect_pc_q;
                    state_d = REQ;
                end else if (bus.do_branch) begin
                    redirect_pc_d = target;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.do_branch) begin
            ifid_valid_d = 1'b0;
            ifid_inst_d  = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            redirect_pc_q <= '0;
            buf_inst_q    <= NOP_INST;
            ifid_valid_q  <= 1'b0;
            ifid_pc_q     <= '0;
            ifid_inst_q   <= NOP_INST;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            buf_inst_q    <= buf_inst_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_inst_q   <= ifid_inst_d;
        end
    end

    assign bus.imem_req   = (state_q == REQ) || (state_q == KILL);
    assign bus.imem_addr  = pc_q;
    assign bus.ifid_valid = ifid_valid_q;
    assign bus.ifid_pc    = ifid_pc_q;
    assign bus.ifid_inst  = ifid_inst_q;
    assign bus.flush_id   = bus.do_branch & rst_n;

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch stage controller for the pipelined RV32 core. It owns the program counter, issues requests to instruction memory over a valid/ready handshake, and loads the IF/ID pipeline register. It is the direct consumer of the EX-stage branch decision (`do_branch` plus target). It redirects fetch on a taken branch or jump, and raises the flush for the instruction currently in ID.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INST`, default 32'h0000_0013: instruction word loaded into IF/ID when it is invalidated (`addi x0,x0,0`).

- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `do_branch` in 1: taken branch, jal or jalr resolved in EX this cycle.
- `branch_target` in 32: redirect address, valid when `do_branch`=1; bits [1:0] are forced to 0.
- `stall` in 1: load-use stall from the hazard unit; PC and IF/ID must hold.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready` in 1: memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: fetched instruction.
- `ifid_valid` out 1: IF/ID holds a live instruction.
- `ifid_pc` out 32: PC of the IF/ID instruction.
- `ifid_inst` out 32: IF/ID instruction word.
- `flush_id` out 1: kill the instruction currently in ID (combinational, equals `do_branch`; 0 while `rst_n`=0).

## Operation
- Registers: `pc`, `redirect_pc`, `buf_inst`, the IF/ID triple, and `state` ∈ {IDLE, REQ, BUF, KILL}.
- Outputs from state:
  - `imem_req` = 1 in REQ and KILL, 0 in IDLE and BUF.
  - `imem_addr` = `pc` in all states.
- IDLE: entered on reset. Goes to REQ on the next cycle. `pc` is unchanged.
- REQ, priority order:
  1. `do_branch` with `imem_ready`: discard `imem_rdata`, `pc`<=target, stay in REQ.
  2. `do_branch` without `imem_ready`: `redirect_pc`<=target, go to KILL. `pc` is held so the address stays stable.
  3. `imem_ready` with no stall: IF/ID<={`pc`, `imem_rdata`, 1}, `pc`<=`pc`+4, stay in REQ.
  4. `imem_ready` with `stall`: `buf_inst`<=`imem_rdata`, go to BUF. IF/ID and `pc` hold.
  5. No ready, no stall: `ifid_valid`<=0, `ifid_inst`<=NOP_INST (bubble).
  6. No ready, with `stall`: IF/ID holds.
- BUF:
  - `do_branch`: drop the buffer, `pc`<=target, go to REQ.
  - Otherwise, if `stall`=0: IF/ID<={`pc`, `buf_inst`, 1}, `pc`<=`pc`+4, go to REQ.
  - Otherwise: hold.
- KILL: waits for the outstanding request to complete and discards its data. IF/ID stays invalid.
  - `imem_ready` with `do_branch`: `pc`<=`branch_target`, go to REQ.
  - `imem_ready` alone: `pc`<=`redirect_pc`, go to REQ.
  - `do_branch` without ready: `redirect_pc`<=target (the latest branch wins).
- In every state, `do_branch`=1 forces `ifid_valid`<=0 and `ifid_inst`<=NOP_INST. `do_branch` overrides `stall`.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values (rst_n sampled low at an edge):
  - state=IDLE, `pc`=RESET_PC, `redirect_pc`=0, `buf_inst`=NOP_INST.
  - `ifid_valid`=0, `ifid_pc`=0, `ifid_inst`=NOP_INST.
  - `imem_req`=0, `flush_id`=0.
- First request: `imem_req`=1 with `imem_addr`=RESET_PC in the 2nd cycle after `rst_n` rises. The first cycle after release is IDLE.
- Fetch latency: data accepted at edge N appears on IF/ID outputs after edge N. With `imem_ready` tied high and no stall, throughput is 1 instruction per cycle.
- Redirect: with `do_branch` at edge N and ready memory, `imem_addr`=target in cycle N+1. The target instruction is in IF/ID after edge N+1.
- Handshake rule: once `imem_req`=1, `imem_req` and `imem_addr` do not change until a cycle with `imem_ready`=1. The only exception is reset.
- Reset mid-operation: reset in REQ, BUF or KILL returns to IDLE at that edge. The outstanding request is abandoned and memory is reset with the core.
- `stall` and `do_branch` in the same cycle: the branch wins and stall is ignored for IF state.

## Test plan
- Reset/stream: hold `rst_n`=0 for 3 cycles, then `imem_ready`=1 throughout.
  - IDLE for 1 cycle, then addresses 0, 4, 8, …
  - `ifid_pc` follows one cycle behind with `ifid_valid`=1.
- Wait states: `imem_ready` low for 3 cycles at addr 0x10.
  - `imem_addr` stays 0x10.
  - 3 bubbles (`ifid_valid`=0, NOP).
  - Then `ifid_pc`=0x10.
- Stall buffering: `stall`=1 for 2 cycles at the same edge that the 0x20 response is accepted.
  - `imem_req`=0 while in BUF.
  - After the stall drops, `ifid_inst` equals the buffered word and the next address is 0x24.
- Branch in KILL: `imem_ready`=0 at addr 0x30, `do_branch` with target 0x100, then `imem_ready`=1 two cycles later.
  - `imem_addr` holds 0x30 until accepted.
  - The 0x30 data is never in IF/ID.
  - The next request is 0x100.
  - `flush_id`=1 only in the branch cycle.
- Priority: `do_branch`=1 (target 0x203) together with `stall`=1 in REQ with ready.
  - `ifid_valid`=0.
  - The next `imem_addr` is 0x200.
- Wrap: `do_branch` to 0xFFFF_FFFC with ready memory.
  - The following fetch address is 0x0000_0000.
